// File: rtl/single_port_sram_pkg.sv
// Shared constants and elaboration-time checks for the single-port SRAM.
package single_port_sram_pkg;

    // Default geometry: 16 words of 8 bits behind a 4-bit address.
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_WORD_DEPTH = 16;
    localparam int DEF_WORD_WIDTH = 8;

    // True when the word count is non-zero and fits the address space.
    function automatic bit depth_fits(input int aw, input int depth);
        longint unsigned span;
        span = longint'(1) << aw;
        return (depth >= 1) && (longint'(depth) <= span);
    endfunction

endpackage

// File: rtl/single_port_sram.sv
// Synchronous single-port RAM with write-first behaviour and a registered,
// asynchronously cleared read port. The array "mem" stays at this level so
// simulation can preload or dump it by hierarchical name.
module single_port_sram
    import single_port_sram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int WORD_DEPTH = DEF_WORD_DEPTH,
    parameter int WORD_WIDTH = DEF_WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WORD_WIDTH-1:0] d_in,
    output logic [WORD_WIDTH-1:0] d_out,
    input  logic                  rst
);

    // Refuse to elaborate a depth the address bus cannot reach.
    generate
        if (!depth_fits(ADDR_WIDTH, WORD_DEPTH)) begin : g_bad_depth
            $error("single_port_sram: WORD_DEPTH must be 1..2**ADDR_WIDTH");
        end
    endgenerate

    // Storage; deliberately not reset so preloaded contents survive.
    logic [WORD_WIDTH-1:0] mem [0:WORD_DEPTH-1];

    logic                  in_range;
    logic [WORD_WIDTH-1:0] rd_next;

    // One spare bit lets the compare hold WORD_DEPTH == 2**ADDR_WIDTH.
    assign in_range = ({1'b0, addr} < (ADDR_WIDTH+1)'(WORD_DEPTH));

    // Write port: blocked while reset is high and for unmapped addresses.
    always_ff @(posedge clk) begin
        if (!rst && we && in_range) begin
            mem[addr] <= d_in;
        end
    end

    // Next read value: write-first on writes, zero for unmapped addresses.
    always_comb begin
        rd_next = '0;
        if (in_range) begin
            rd_next = we ? d_in : mem[addr];
        end
    end

    // Output register, cleared immediately on reset assertion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_out <= '0;
        end else begin
            d_out <= rd_next;
        end
    end

endmodule

// File: tb/tb_single_port_sram.sv
// Directed self-checking bench for single_port_sram (full-depth and
// reduced-depth instances).
module tb_single_port_sram;

    logic       clk;
    logic       rst;
    logic       we,  we2;
    logic [3:0] addr, addr2;
    logic [7:0] d_in, d_in2;
    logic [7:0] d_out, d_out2;

    int checks;
    int failures;

    logic [7:0] pre [16];

    single_port_sram #(.ADDR_WIDTH(4), .WORD_DEPTH(16), .WORD_WIDTH(8)) dut (
        .clk(clk), .we(we), .addr(addr), .d_in(d_in), .d_out(d_out), .rst(rst)
    );

    single_port_sram #(.ADDR_WIDTH(4), .WORD_DEPTH(12), .WORD_WIDTH(8)) dut12 (
        .clk(clk), .we(we2), .addr(addr2), .d_in(d_in2), .d_out(d_out2), .rst(rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (d_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_dout got=%h exp=00", d_out);
        end
        checks++;
        if (d_out2 !== 8'h00) begin
            failures++;
            $display("FAIL reset_dout12 got=%h exp=00", d_out2);
        end
        rst = 1'b0;
    endtask

    task automatic test_preload_read();
        logic [7:0] dv [4];
        dv[0] = 8'b11110000; dv[1] = 8'b11001100;
        dv[2] = 8'b00001111; dv[3] = 8'b10101010;
        // Load the preload image through the write port.
        for (int i = 0; i < 16; i++) begin
            we = 1'b1; addr = 4'(i); d_in = pre[i];
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            we = 1'b0; addr = 4'(i); d_in = dv[i];
            tick();
            checks++;
            if (d_out !== pre[i]) begin
                failures++;
                $display("FAIL preload_read[%0d] got=%h exp=%h", i, d_out, pre[i]);
            end
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (dut.mem[i] !== pre[i]) begin
                failures++;
                $display("FAIL preload_dump[%0d] got=%h exp=%h", i, dut.mem[i], pre[i]);
            end
        end
    endtask

    task automatic test_write_read();
        logic [7:0] wv [4];
        wv[0] = 8'hF0; wv[1] = 8'hCC; wv[2] = 8'h0F; wv[3] = 8'hAA;
        for (int i = 0; i < 4; i++) begin
            we = 1'b1; addr = 4'(i); d_in = wv[i];
            tick();
            checks++;
            if (d_out !== wv[i]) begin
                failures++;
                $display("FAIL write_first[%0d] got=%h exp=%h", i, d_out, wv[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            we = 1'b0; addr = 4'(i); d_in = 8'h00;
            tick();
            checks++;
            if (d_out !== wv[i]) begin
                failures++;
                $display("FAIL readback[%0d] got=%h exp=%h", i, d_out, wv[i]);
            end
        end
        for (int i = 4; i < 16; i++) begin
            checks++;
            if (dut.mem[i] !== pre[i]) begin
                failures++;
                $display("FAIL untouched[%0d] got=%h exp=%h", i, dut.mem[i], pre[i]);
            end
        end
    endtask

    task automatic test_read_during_write();
        we = 1'b1; addr = 4'd7; d_in = 8'h5A;
        tick();
        checks++;
        if (d_out !== 8'h5A) begin
            failures++;
            $display("FAIL rdw_same_edge got=%h exp=5a", d_out);
        end
        we = 1'b0; addr = 4'd7; d_in = 8'h00;
        tick();
        checks++;
        if (d_out !== 8'h5A) begin
            failures++;
            $display("FAIL rdw_readback got=%h exp=5a", d_out);
        end
    endtask

    task automatic test_async_reset();
        we = 1'b0; addr = 4'd3; d_in = 8'h00;
        tick();
        checks++;
        if (d_out !== 8'hAA) begin
            failures++;
            $display("FAIL pre_reset_dout got=%h exp=aa", d_out);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (d_out !== 8'h00) begin
            failures++;
            $display("FAIL async_clear got=%h exp=00", d_out);
        end
        we = 1'b1; addr = 4'd3; d_in = 8'h11;
        tick();
        checks++;
        if (dut.mem[3] !== 8'hAA) begin
            failures++;
            $display("FAIL write_blocked got=%h exp=aa", dut.mem[3]);
        end
        checks++;
        if (d_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_hold got=%h exp=00", d_out);
        end
        rst = 1'b0;
        we = 1'b0; addr = 4'd3; d_in = 8'h00;
        tick();
        checks++;
        if (d_out !== 8'hAA) begin
            failures++;
            $display("FAIL post_reset_read got=%h exp=aa", d_out);
        end
    endtask

    task automatic test_last_word();
        we = 1'b1; addr = 4'd15; d_in = 8'hFF;
        tick();
        we = 1'b0; addr = 4'd15; d_in = 8'h00;
        tick();
        checks++;
        if (d_out !== 8'hFF) begin
            failures++;
            $display("FAIL last_word got=%h exp=ff", d_out);
        end
        addr = 4'd0;
        tick();
        checks++;
        if (d_out !== 8'hF0) begin
            failures++;
            $display("FAIL no_alias got=%h exp=f0", d_out);
        end
    endtask

    task automatic test_out_of_range();
        for (int i = 0; i < 12; i++) begin
            we2 = 1'b1; addr2 = 4'(i); d_in2 = 8'h10 + 8'(i);
            tick();
        end
        we2 = 1'b1; addr2 = 4'd13; d_in2 = 8'h77;
        tick();
        we2 = 1'b0; addr2 = 4'd13; d_in2 = 8'h00;
        tick();
        checks++;
        if (d_out2 !== 8'h00) begin
            failures++;
            $display("FAIL oor_read got=%h exp=00", d_out2);
        end
        addr2 = 4'd11;
        tick();
        checks++;
        if (d_out2 !== 8'h1B) begin
            failures++;
            $display("FAIL oor_last_valid got=%h exp=1b", d_out2);
        end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (dut12.mem[i] !== 8'h10 + 8'(i)) begin
                failures++;
                $display("FAIL oor_mem[%0d] got=%h exp=%h", i, dut12.mem[i], 8'h10 + 8'(i));
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        pre[0]  = 8'h01; pre[1]  = 8'h23; pre[2]  = 8'h45; pre[3]  = 8'h67;
        pre[4]  = 8'h89; pre[5]  = 8'hAB; pre[6]  = 8'hCD; pre[7]  = 8'hEF;
        pre[8]  = 8'h10; pre[9]  = 8'h32; pre[10] = 8'h54; pre[11] = 8'h76;
        pre[12] = 8'h98; pre[13] = 8'hBA; pre[14] = 8'hDC; pre[15] = 8'hFE;
        rst = 1'b1;
        we = 1'b0;  addr = '0;  d_in = '0;
        we2 = 1'b0; addr2 = '0; d_in2 = '0;
        tick();
        tick();
        test_reset();
        test_preload_read();
        test_write_read();
        test_read_during_write();
        test_async_reset();
        test_last_word();
        test_out_of_range();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/single_port_sram.md
# single_port_sram

Synchronous single-port static RAM: one address bus shared by reads and writes, one write-data bus, one registered read-data bus. Used as a general-purpose small scratch/lookup memory. The storage array is directly accessible by hierarchical name, so simulation can preload it and dump it from file.

## Interface
- Parameters:
  - `ADDR_WIDTH`, default 4: address bus width.
  - `WORD_DEPTH`, default 16: number of words; must be ≤ 2^ADDR_WIDTH.
  - `WORD_WIDTH`, default 8: bits per word.
- Ports:
  - `clk`, input, 1 bit: single clock; all state updates on its rising edge.
  - `rst`, input, 1 bit: asynchronous, active-high reset.
  - `we`, input, 1 bit: write enable. 1 = write, 0 = read.
  - `addr`, input, `ADDR_WIDTH` bits: word address.
  - `d_in`, input, `WORD_WIDTH` bits: write data.
  - `d_out`, output, `WORD_WIDTH` bits: registered read data.
- Port order for positional instantiation: `clk`, `we`, `addr`, `d_in`, `d_out`, `rst`.
- Storage is a register array named `mem`, indexed `[0:WORD_DEPTH-1]`, each entry `WORD_WIDTH` wide, declared at the top level of the module. It must be visible to `$readmemb` and hierarchical reads.

## Operation
- **Write** (`we`=1 at a rising edge): `mem[addr]` <= `d_in`.
- **Read** (`we`=0 at a rising edge): `d_out` <= `mem[addr]`. The array is unchanged.
- **Read-during-write:** write-first. On a write edge, `d_out` <= `d_in`, the same value just written.
- **Out-of-range address** (`addr` ≥ `WORD_DEPTH`, only possible when `WORD_DEPTH` < 2^`ADDR_WIDTH`):
  - writes are ignored;
  - reads load 0 into `d_out`.
- **Reset:**
  - `d_out` is cleared to 0 immediately on assertion of `rst`, without waiting for a clock edge.
  - `mem` is NOT cleared by reset, so preloaded contents survive.
- While `rst` is high:
  - writes are blocked;
  - `d_out` holds 0.
- No uninitialized X is ever driven on `d_out` after reset.
- No initial contents are built in. Contents come from writes or from a simulation preload.

## Timing
- Read latency: 1 cycle. Address sampled at edge N; data valid on `d_out` after edge N and stable until edge N+1.
- Write latency: `mem` updated at the sampling edge. A read of the same address at edge N+1 returns the new data.
- No handshake: every cycle is exactly one read or one write.
- Reset release: the first edge with `rst` low performs a normal access.
- Reset asserted mid-access: the in-flight edge is discarded, and `d_out` goes to 0 asynchronously.
- Back-to-back writes to the same address: the last write wins.

## Structure
- A shared package holds the default constants `ADDR_WIDTH`=4, `WORD_DEPTH`=16 and `WORD_WIDTH`=8. It also holds a width-check helper ensuring `WORD_DEPTH` ≤ 2^`ADDR_WIDTH`; an elaboration error is raised otherwise.
- No sub-module is needed. Array, write port and read register live in one module so that `mem` stays at the top hierarchy level.
- Optional sub-module: a parameterized `sram_out_reg` for the async-reset output register.

## Test plan
- **Preload and read:** `$readmemb` a 16-word file into `mem`. Hold `we`=0 and step `addr` 0,1,2,3 while driving `d_in` = 8'b11110000, 8'b11001100, 8'b00001111, 8'b10101010.
  - Each `d_out` equals the file word one cycle later.
  - `mem` is unchanged; a dump of all 16 words matches the file.
- **Write then read back:** with `we`=1, write addr 0..3 with 8'hF0, 8'hCC, 8'h0F, 8'hAA. Then with `we`=0, read addr 0..3.
  - `d_out` returns F0, CC, 0F, AA, each with 1-cycle latency.
  - `mem[4..15]` is untouched.
- **Read-during-write:** write 8'h5A to addr 7.
  - `d_out` = 8'h5A after that same edge.
  - A following read of addr 7 gives 5A.
- **Asynchronous reset:** while `d_out`=8'hAA, assert `rst` between clock edges.
  - `d_out` = 0 immediately.
  - Writes attempted during reset do not change `mem`.
  - After release, a read of addr 3 returns 8'hAA, showing `mem` was preserved.
- **Address wrap and last word:** write 8'hFF to addr 15, then read addr 15 and addr 0.
  - Reads return FF and the addr-0 value respectively, with no aliasing.
- **Out of range** (instance with `WORD_DEPTH`=12): write to addr 13, then read addr 13.
  - `d_out` = 0.
  - `mem[0..11]` is unchanged.
